// File: rtl/mode_counter.sv
// mode_counter: one 8254-style timer channel with a parametrised width.
//
// Operating modes (selected by mode, sampled on load):
//   0 interrupt-on-terminal-count, 1 retriggerable one-shot,
//   2 rate generator, 3 square wave.
//
// Ports:
//   clk        system clock, all state changes on the rising edge
//   rst        asynchronous active-low reset
//   load       capture count_in and mode, (re)start the channel
//   mode       operating mode, sampled only on load
//   count_in   initial/reload value; 0 encodes the full range
//   gate       count enable (modes 0,2,3) or trigger (mode 1)
//   latch      level: freeze count_out while high
//   out        channel output waveform
//   tc         one-cycle terminal-count pulse
//   count_out  registered read-back of the current count
//
// Build option: define COUNTER_BCD_EN to add the bcd input (sampled on
// load). With bcd=1 modes 0,1,2 count as WIDTH/4 packed BCD digits;
// mode 3 always counts binary. Without the macro all counting is binary.
module mode_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] count_in,
  input  logic             gate,
  input  logic             latch,
`ifdef COUNTER_BCD_EN
  input  logic             bcd,
`endif
  output logic             out,
  output logic             tc,
  output logic [WIDTH-1:0] count_out
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [WIDTH-1:0] count_reg,     count_next;
  logic [WIDTH-1:0] reload_reg,    reload_next;
  logic [1:0]       mode_reg,      mode_next;
  logic [1:0]       state_reg,     state_next;
  logic             out_reg,       out_next;
  logic             tc_reg,        tc_next;
  logic [WIDTH-1:0] count_out_reg, count_out_next;
  logic             gate_q_reg;
  logic             latch_q_reg;

  logic             gate_rise;
  logic             count_is_one;
  logic [WIDTH-1:0] dec_val;
  logic [WIDTH-1:0] rate_reload;

  // Length of one square-wave phase for a programmed value n.
  // n=0 means 2^WIDTH and n=1 behaves as 2; high phase is ceil, low is floor.
  function automatic logic [WIDTH-1:0] phase_len(input logic [WIDTH-1:0] n,
                                                 input logic high);
    logic [WIDTH:0] e;
    logic [WIDTH:0] s;
    if (n == '0)
      e = {1'b1, {WIDTH{1'b0}}};
    else if (n == WIDTH'(1))
      e = (WIDTH+1)'(2);
    else
      e = {1'b0, n};
    s = high ? e + 1'b1 : e;
    return s[WIDTH:1];
  endfunction

  assign gate_rise    = gate & ~gate_q_reg;
  assign count_is_one = (count_reg == WIDTH'(1));
  // A rate generator programmed with 1 would never show a low cycle,
  // so it runs with a period of 2 instead.
  assign rate_reload  = (reload_reg == WIDTH'(1)) ? WIDTH'(2) : reload_reg;

`ifdef COUNTER_BCD_EN
  localparam int DIGITS = WIDTH / 4;
  logic             bcd_reg, bcd_next;
  logic [WIDTH-1:0] bcd_dec;
  logic [DIGITS-1:0] borrow;
  genvar gi;

  // Digit-serial BCD decrement: a digit borrows from the next one up
  // only when it is 0 and itself receives a borrow, so 0..0 wraps to 9..9.
  assign borrow[0] = 1'b1;
  generate
    for (gi = 0; gi < DIGITS; gi++) begin : g_bcd
      logic [3:0] digit;
      assign digit = count_reg[4*gi +: 4];
      assign bcd_dec[4*gi +: 4] = !borrow[gi]        ? digit :
                                  (digit == 4'd0)    ? 4'd9  : digit - 4'd1;
      if (gi < DIGITS - 1) begin : g_borrow
        assign borrow[gi+1] = borrow[gi] & (digit == 4'd0);
      end
    end
  endgenerate

  assign dec_val  = (bcd_reg && mode_reg != 2'd3) ? bcd_dec : count_reg - WIDTH'(1);
  assign bcd_next = load ? bcd : bcd_reg;
`else
  assign dec_val = count_reg - WIDTH'(1);
`endif

  always_comb begin
    count_next  = count_reg;
    reload_next = reload_reg;
    mode_next   = mode_reg;
    state_next  = state_reg;
    out_next    = out_reg;
    tc_next     = 1'b0;

    if (load) begin
      // Load wins over any terminal count, gate edge or decrement.
      reload_next = count_in;
      mode_next   = mode;
      case (mode)
        2'd0: begin
          count_next = count_in;
          out_next   = 1'b0;
          state_next = S_RUN;
        end
        2'd1: begin
          // One-shot arms and waits in DONE for a gate rising edge.
          count_next = count_in;
          out_next   = 1'b1;
          state_next = S_DONE;
        end
        2'd2: begin
          count_next = (count_in == WIDTH'(1)) ? WIDTH'(2) : count_in;
          out_next   = 1'b1;
          state_next = S_RUN;
        end
        default: begin
          count_next = phase_len(count_in, 1'b1);
          out_next   = 1'b1;
          state_next = S_RUN;
        end
      endcase
    end else begin
      case (mode_reg)
        2'd0: begin
          if (state_reg == S_RUN && gate) begin
            if (count_is_one) begin
              count_next = '0;
              out_next   = 1'b1;
              tc_next    = 1'b1;
              state_next = S_DONE;
            end else begin
              count_next = dec_val;
            end
          end
        end
        2'd1: begin
          if (state_reg != S_IDLE && gate_rise) begin
            // Trigger or retrigger: restart the full count.
            count_next = reload_reg;
            out_next   = 1'b0;
            state_next = S_RUN;
          end else if (state_reg == S_RUN) begin
            if (count_is_one) begin
              count_next = '0;
              out_next   = 1'b1;
              tc_next    = 1'b1;
              state_next = S_DONE;
            end else begin
              count_next = dec_val;
            end
          end
        end
        2'd2: begin
          if (state_reg == S_RUN) begin
            if (!gate) begin
              out_next = 1'b1;
            end else if (gate_rise) begin
              count_next = rate_reload;
              out_next   = 1'b1;
            end else if (count_is_one) begin
              count_next = rate_reload;
              out_next   = 1'b1;
              tc_next    = 1'b1;
            end else begin
              count_next = dec_val;
              // out is low exactly for the cycle the count sits at 1.
              out_next   = (dec_val != WIDTH'(1));
            end
          end
        end
        default: begin
          if (state_reg == S_RUN) begin
            if (!gate) begin
              out_next = 1'b1;
            end else if (gate_rise) begin
              count_next = phase_len(reload_reg, 1'b1);
              out_next   = 1'b1;
            end else if (count_is_one) begin
              // Leaving the high phase loads the low length and vice versa.
              out_next   = ~out_reg;
              count_next = phase_len(reload_reg, ~out_reg);
              tc_next    = out_reg;
            end else begin
              count_next = count_reg - WIDTH'(1);
            end
          end
        end
      endcase
    end
  end

  // Capture on the first edge latch is seen high, then hold.
  always_comb begin
    count_out_next = count_out_reg;
    if (!latch || !latch_q_reg)
      count_out_next = count_reg;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_reg     <= '0;
      reload_reg    <= '0;
      mode_reg      <= 2'd0;
      state_reg     <= S_IDLE;
      out_reg       <= 1'b1;
      tc_reg        <= 1'b0;
      count_out_reg <= '0;
      gate_q_reg    <= 1'b0;
      latch_q_reg   <= 1'b0;
    end else begin
      count_reg     <= count_next;
      reload_reg    <= reload_next;
      mode_reg      <= mode_next;
      state_reg     <= state_next;
      out_reg       <= out_next;
      tc_reg        <= tc_next;
      count_out_reg <= count_out_next;
      gate_q_reg    <= gate;
      latch_q_reg   <= latch;
    end
  end

`ifdef COUNTER_BCD_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      bcd_reg <= 1'b0;
    else
      bcd_reg <= bcd_next;
  end
`endif

  assign out       = out_reg;
  assign tc        = tc_reg;
  assign count_out = count_out_reg;

endmodule
